// File: rtl/bus_cycle_pkg.sv
// Purpose: shared region/state encodings and default wait-state constants for the 68000 bus cycle controller.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package bus_cycle_pkg;

    // Region code reported on CycleRegion; values are visible to software and must not move.
    typedef enum logic [2:0] {
        REGION_NONE = 3'd0,
        REGION_ROM  = 3'd1,
        REGION_RAM  = 3'd2,
        REGION_IO   = 3'd3,
        REGION_CAN  = 3'd4,
        REGION_DRAM = 3'd5
    } region_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DRAM = 3'd2,
        ST_ACK  = 3'd3,
        ST_BERR = 3'd4
    } state_t;

    localparam int DEF_ROM_WAIT       = 1;
    localparam int DEF_RAM_WAIT       = 0;
    localparam int DEF_IO_WAIT        = 3;
    localparam int DEF_CAN_WAIT       = 2;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    // Bits needed to hold 0..max_value; never less than one bit.
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Purpose: loadable, clearable saturating down-counter with a zero flag.
// Latency: load/clear/decrement take effect on the next rising edge; zero is combinational from the count.
// Backpressure: none; decrement at zero holds at zero instead of wrapping.
module bus_timeout_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             decrement,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // Clear beats load beats decrement; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bus_cycle_controller.sv
// Purpose: sequences 68000 bus cycles, generating Dtack_L per region wait states and BErr_L (macro BUS_TIMEOUT_EN).
// Latency: Dtack_L low W+1 edges after the request edge; DRAM ack one edge after DramDtack_L is sampled low.
// Backpressure: the CPU holds AS_L low until acknowledged; AS_L negation aborts or ends the cycle.
module bus_cycle_controller
    import bus_cycle_pkg::*;
#(
    parameter int ROM_WAIT       = DEF_ROM_WAIT,
    parameter int RAM_WAIT       = DEF_RAM_WAIT,
    parameter int IO_WAIT        = DEF_IO_WAIT,
    parameter int CAN_WAIT       = DEF_CAN_WAIT,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic    Clk,
    input  logic    Reset_L,
    input  logic    AS_L,
    input  logic    UDS_L,
    input  logic    LDS_L,
    input  logic    OnChipRomSelect_H,
    input  logic    OnChipRamSelect_H,
    input  logic    IOSelect_H,
    input  logic    CanBusSelect_H,
    input  logic    DramSelect_H,
    input  logic    DramDtack_L,
    output logic    Dtack_L,
    output logic    BErr_L,
    output region_t CycleRegion
);

    localparam int WAIT_W = cnt_width(max4(ROM_WAIT, RAM_WAIT, IO_WAIT, CAN_WAIT));

    state_t              state;
    logic                request;
    region_t             sel_region;
    logic [WAIT_W-1:0]   sel_wait;
    logic                cnt_load;
    logic                cnt_clear;
    logic                wait_dec;
    logic                wait_zero;
    logic [WAIT_W-1:0]   wait_count_unused;
    logic                timeout_fire;

    assign request = !AS_L && (!UDS_L || !LDS_L);

    // Fixed-priority region pick from the decoder selects: ROM > RAM > IO > CAN > DRAM.
    always_comb begin
        sel_region = REGION_NONE;
        sel_wait   = '0;
        if (OnChipRomSelect_H) begin
            sel_region = REGION_ROM;
            sel_wait   = WAIT_W'(ROM_WAIT);
        end else if (OnChipRamSelect_H) begin
            sel_region = REGION_RAM;
            sel_wait   = WAIT_W'(RAM_WAIT);
        end else if (IOSelect_H) begin
            sel_region = REGION_IO;
            sel_wait   = WAIT_W'(IO_WAIT);
        end else if (CanBusSelect_H) begin
            sel_region = REGION_CAN;
            sel_wait   = WAIT_W'(CAN_WAIT);
        end else if (DramSelect_H) begin
            sel_region = REGION_DRAM;
        end
    end

    // Counters load on the request edge and clear whenever AS_L is seen high inside a cycle.
    assign cnt_load  = (state == ST_IDLE) && request;
    assign cnt_clear = (state != ST_IDLE) && AS_L;
    assign wait_dec  = (state == ST_WAIT) && (CycleRegion != REGION_NONE);

    bus_timeout_counter #(
        .WIDTH(WAIT_W)
    ) u_wait_cnt (
        .clk       (Clk),
        .reset_l   (Reset_L),
        .clear     (cnt_clear),
        .load      (cnt_load),
        .load_value(sel_wait),
        .decrement (wait_dec),
        .count     (wait_count_unused),
        .zero      (wait_zero)
    );

`ifdef BUS_TIMEOUT_EN
    localparam int TO_W = cnt_width(TIMEOUT_CYCLES);

    logic              to_dec;
    logic              to_zero;
    logic [TO_W-1:0]   to_count_unused;
    logic              berr_q;

    // Loaded with TIMEOUT_CYCLES-1 so zero is reached on the TIMEOUT_CYCLES-th edge in WAIT/DRAM.
    assign to_dec = ((state == ST_WAIT) || (state == ST_DRAM)) && !AS_L;

    bus_timeout_counter #(
        .WIDTH(TO_W)
    ) u_timeout_cnt (
        .clk       (Clk),
        .reset_l   (Reset_L),
        .clear     (cnt_clear),
        .load      (cnt_load),
        .load_value(TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0)),
        .decrement (to_dec),
        .count     (to_count_unused),
        .zero      (to_zero)
    );

    assign timeout_fire = to_zero;
    assign BErr_L       = berr_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_fire   = 1'b0;
    assign BErr_L         = 1'b1;
`endif

    // Cycle FSM with registered Dtack/BErr/region; acknowledge always wins over timeout.
    always_ff @(posedge Clk) begin
        if (!Reset_L) begin
            state       <= ST_IDLE;
            Dtack_L     <= 1'b1;
            CycleRegion <= REGION_NONE;
`ifdef BUS_TIMEOUT_EN
            berr_q      <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (request) begin
                        CycleRegion <= sel_region;
                        state       <= (sel_region == REGION_DRAM) ? ST_DRAM : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (AS_L) begin
                        state       <= ST_IDLE;
                        CycleRegion <= REGION_NONE;
                    end else if ((CycleRegion != REGION_NONE) && wait_zero) begin
                        state   <= ST_ACK;
                        Dtack_L <= 1'b0;
                    end else if (timeout_fire) begin
                        state <= ST_BERR;
`ifdef BUS_TIMEOUT_EN
                        berr_q <= 1'b0;
`endif
                    end
                end
                ST_DRAM: begin
                    if (AS_L) begin
                        state       <= ST_IDLE;
                        CycleRegion <= REGION_NONE;
                    end else if (!DramDtack_L) begin
                        state   <= ST_ACK;
                        Dtack_L <= 1'b0;
                    end else if (timeout_fire) begin
                        state <= ST_BERR;
`ifdef BUS_TIMEOUT_EN
                        berr_q <= 1'b0;
`endif
                    end
                end
                ST_ACK: begin
                    if (AS_L) begin
                        state       <= ST_IDLE;
                        Dtack_L     <= 1'b1;
                        CycleRegion <= REGION_NONE;
                    end
                end
                ST_BERR: begin
                    if (AS_L) begin
                        state       <= ST_IDLE;
                        CycleRegion <= REGION_NONE;
`ifdef BUS_TIMEOUT_EN
                        berr_q      <= 1'b1;
`endif
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    Dtack_L     <= 1'b1;
                    CycleRegion <= REGION_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Purpose: directed self-checking bench for bus_cycle_controller (honours BUS_TIMEOUT_EN when defined).
// Latency: checks are taken 1ns after each rising edge, counting edges from the request edge.
// Backpressure: the bench plays the CPU, holding AS_L low until it chooses to end the cycle.
module tb_bus_cycle_controller;
    import bus_cycle_pkg::*;

    logic    Clk;
    logic    Reset_L;
    logic    AS_L, UDS_L, LDS_L;
    logic    OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, CanBusSelect_H, DramSelect_H;
    logic    DramDtack_L;
    logic    Dtack_L, BErr_L;
    region_t CycleRegion;

    int n_cmp = 0;
    int n_err = 0;

    bus_cycle_controller #(
        .ROM_WAIT(1), .RAM_WAIT(0), .IO_WAIT(3), .CAN_WAIT(2), .TIMEOUT_CYCLES(8)
    ) dut (
        .Clk              (Clk),
        .Reset_L          (Reset_L),
        .AS_L             (AS_L),
        .UDS_L            (UDS_L),
        .LDS_L            (LDS_L),
        .OnChipRomSelect_H(OnChipRomSelect_H),
        .OnChipRamSelect_H(OnChipRamSelect_H),
        .IOSelect_H       (IOSelect_H),
        .CanBusSelect_H   (CanBusSelect_H),
        .DramSelect_H     (DramSelect_H),
        .DramDtack_L      (DramDtack_L),
        .Dtack_L          (Dtack_L),
        .BErr_L           (BErr_L),
        .CycleRegion      (CycleRegion)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drive a request with the given selects {rom,ram,io,can,dram}; sampled at the next edge.
    task automatic start_cycle(input logic [4:0] sel, input logic uds, input logic lds);
        {OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, CanBusSelect_H, DramSelect_H} = sel;
        AS_L  = 1'b0;
        UDS_L = uds;
        LDS_L = lds;
    endtask

    task automatic end_cycle();
        AS_L  = 1'b1;
        UDS_L = 1'b1;
        LDS_L = 1'b1;
        {OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, CanBusSelect_H, DramSelect_H} = 5'b0;
    endtask

    task automatic test_reset();
        Reset_L = 1'b0;
        end_cycle();
        DramDtack_L = 1'b1;
        tick();
        tick();
        n_cmp++; if (Dtack_L !== 1'b1) begin n_err++; $display("FAIL reset_dtack: got %b want 1", Dtack_L); end
        n_cmp++; if (BErr_L !== 1'b1) begin n_err++; $display("FAIL reset_berr: got %b want 1", BErr_L); end
        n_cmp++; if (CycleRegion !== REGION_NONE) begin n_err++; $display("FAIL reset_region: got %0d want 0", CycleRegion); end
        Reset_L = 1'b1;
        tick();
    endtask

    task automatic test_ram_read();
        start_cycle(5'b01000, 1'b0, 1'b0);
        tick(); // request edge
        n_cmp++; if (Dtack_L !== 1'b1) begin n_err++; $display("FAIL ram_e0_dtack: got %b want 1", Dtack_L); end
        n_cmp++; if (CycleRegion !== REGION_RAM) begin n_err++; $display("FAIL ram_region: got %0d want 2", CycleRegion); end
        tick();
        n_cmp++; if (Dtack_L !== 1'b0) begin n_err++; $display("FAIL ram_e1_dtack: got %b want 0", Dtack_L); end
        tick();
        n_cmp++; if (Dtack_L !== 1'b0) begin n_err++; $display("FAIL ram_hold_dtack: got %b want 0", Dtack_L); end
        end_cycle();
        tick();
        n_cmp++; if (Dtack_L !== 1'b1) begin n_err++; $display("FAIL ram_release_dtack: got %b want 1", Dtack_L); end
        tick();
    endtask

    task automatic test_io_write();
        start_cycle(5'b00100, 1'b0, 1'b1);
        tick();
        n_cmp++; if (CycleRegion !== REGION_IO) begin n_err++; $display("FAIL io_region: got %0d want 3", CycleRegion); end
        // Selects move after the request edge; the latched region must not follow.
        {OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H} = 3'b010;
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_cmp++; if (Dtack_L !== 1'b1) begin n_err++; $display("FAIL io_wait_e%0d: got %b want 1", e, Dtack_L); end
        end
        tick();
        n_cmp++; if (Dtack_L !== 1'b0) begin n_err++; $display("FAIL io_e4_dtack: got %b want 0", Dtack_L); end
        n_cmp++; if (CycleRegion !== REGION_IO) begin n_err++; $display("FAIL io_region_held: got %0d want 3", CycleRegion); end
        for (int e = 0; e < 3; e++) begin
            tick();
            n_cmp++; if (Dtack_L !== 1'b0) begin n_err++; $display("FAIL io_hold_%0d: got %b want 0", e, Dtack_L); end
        end
        end_cycle();
        tick();
        n_cmp++; if (Dtack_L !== 1'b1) begin n_err++; $display("FAIL io_release_dtack: got %b want 1", Dtack_L); end
        tick();
    endtask

    task automatic test_dram();
        DramDtack_L = 1'b1;
        start_cycle(5'b00001, 1'b0, 1'b0);
        tick();
        n_cmp++; if (CycleRegion !== REGION_DRAM) begin n_err++; $display("FAIL dram_region: got %0d want 5", CycleRegion); end
        for (int e = 1; e <= 6; e++) begin
            tick();
            n_cmp++; if (Dtack_L !== 1'b1) begin n_err++; $display("FAIL dram_wait_e%0d: got %b want 1", e, Dtack_L); end
        end
        DramDtack_L = 1'b0;
        tick();
        n_cmp++; if (Dtack_L !== 1'b0) begin n_err++; $display("FAIL dram_e7_dtack: got %b want 0", Dtack_L); end
        end_cycle();
        DramDtack_L = 1'b1;
        tick();
        n_cmp++; if (Dtack_L !== 1'b1) begin n_err++; $display("FAIL dram_release_dtack: got %b want 1", Dtack_L); end
        tick();
    endtask

    task automatic test_priority();
        start_cycle(5'b10100, 1'b1, 1'b0);
        tick();
        n_cmp++; if (CycleRegion !== REGION_ROM) begin n_err++; $display("FAIL prio_region: got %0d want 1", CycleRegion); end
        tick();
        n_cmp++; if (Dtack_L !== 1'b1) begin n_err++; $display("FAIL prio_e1_dtack: got %b want 1", Dtack_L); end
        tick();
        n_cmp++; if (Dtack_L !== 1'b0) begin n_err++; $display("FAIL prio_e2_dtack: got %b want 0", Dtack_L); end
        end_cycle();
        tick();
        tick();
    endtask

    task automatic test_unmapped();
        start_cycle(5'b00000, 1'b0, 1'b0);
        tick();
`ifdef BUS_TIMEOUT_EN
        for (int e = 1; e <= 7; e++) begin
            tick();
            n_cmp++; if (BErr_L !== 1'b1) begin n_err++; $display("FAIL unmap_berr_e%0d: got %b want 1", e, BErr_L); end
        end
        tick();
        n_cmp++; if (BErr_L !== 1'b0) begin n_err++; $display("FAIL unmap_berr_e8: got %b want 0", BErr_L); end
        n_cmp++; if (Dtack_L !== 1'b1) begin n_err++; $display("FAIL unmap_dtack_e8: got %b want 1", Dtack_L); end
        tick();
        n_cmp++; if (BErr_L !== 1'b0) begin n_err++; $display("FAIL unmap_berr_hold: got %b want 0", BErr_L); end
        end_cycle();
        tick();
        n_cmp++; if (BErr_L !== 1'b1) begin n_err++; $display("FAIL unmap_berr_release: got %b want 1", BErr_L); end
`else
        for (int e = 1; e <= 20; e++) begin
            tick();
            n_cmp++; if ({Dtack_L, BErr_L} !== 2'b11) begin n_err++; $display("FAIL unmap_stall_e%0d: got %b want 11", e, {Dtack_L, BErr_L}); end
        end
        end_cycle();
        tick();
        n_cmp++; if ({Dtack_L, BErr_L} !== 2'b11) begin n_err++; $display("FAIL unmap_release: got %b want 11", {Dtack_L, BErr_L}); end
`endif
        tick();
        // Controller must be back in IDLE: a RAM cycle acknowledges on the next edge.
        start_cycle(5'b01000, 1'b0, 1'b0);
        tick();
        tick();
        n_cmp++; if (Dtack_L !== 1'b0) begin n_err++; $display("FAIL unmap_then_ram: got %b want 0", Dtack_L); end
        end_cycle();
        tick();
        tick();
    endtask

    task automatic test_abort();
        start_cycle(5'b00100, 1'b0, 1'b0);
        tick(); // counter loaded with 3
        tick(); // counter at 2
        end_cycle();
        for (int e = 2; e <= 6; e++) begin
            tick();
            n_cmp++; if (Dtack_L !== 1'b1) begin n_err++; $display("FAIL abort_e%0d_dtack: got %b want 1", e, Dtack_L); end
        end
        // Back-to-back: a fresh RAM cycle starts cleanly from IDLE.
        start_cycle(5'b01000, 1'b0, 1'b0);
        tick();
        n_cmp++; if (CycleRegion !== REGION_RAM) begin n_err++; $display("FAIL abort_next_region: got %0d want 2", CycleRegion); end
        tick();
        n_cmp++; if (Dtack_L !== 1'b0) begin n_err++; $display("FAIL abort_next_dtack: got %b want 0", Dtack_L); end
        end_cycle();
        tick();
        tick();
    endtask

    task automatic test_reset_in_ack();
        start_cycle(5'b01000, 1'b0, 1'b0);
        tick();
        tick();
        n_cmp++; if (Dtack_L !== 1'b0) begin n_err++; $display("FAIL rst_ack_pre: got %b want 0", Dtack_L); end
        Reset_L = 1'b0;
        tick();
        n_cmp++; if (Dtack_L !== 1'b1) begin n_err++; $display("FAIL rst_ack_dtack: got %b want 1", Dtack_L); end
        n_cmp++; if (CycleRegion !== REGION_NONE) begin n_err++; $display("FAIL rst_ack_region: got %0d want 0", CycleRegion); end
        Reset_L = 1'b1;
        end_cycle();
        tick();
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_io_write();
        test_dram();
        test_priority();
        test_unmapped();
        test_abort();
        test_reset_in_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
